sincos_burst_sched: RTL and testbench
=====================================

// Module: sincos_burst_sched
// PURPOSE
//  Shares one Minsky-rotation sin/cos oscillator among NUM_REQ requesters.
//  Each requester asks for a burst of samples; round-robin arbiter grants the burst.
//  Controller seeds the oscillator, steps it under valid/ready backpressure and tags samples.
//  Sits between the waveform oscillator datapath and its consumers (modulators, test tone mux).
// PARAMETERS
//  WIDTH    16  signed sample width; amplitude R = 2**(WIDTH-2) (16384 at default)
//  N        5   rotation shift; step angle ~2**-N rad
//  NUM_REQ  4   number of requesters (>=2)
//  LEN_W    8   burst length field width
// PORTS
//  clk          in   1                clock
//  reset_n      in   1                synchronous reset, active low
//  req          in   NUM_REQ          level request per requester
//  req_len      in   NUM_REQ*LEN_W    burst length; requester i at [i*LEN_W +: LEN_W]
//  gnt          out  NUM_REQ          one-hot, one-cycle pulse when burst accepted
//  busy         out  1                high from grant until after the final sample handshake
//  sample_valid out  1                sample present
//  sample_ready in   1                consumer accepts sample
//  sample_sin   out  WIDTH            signed sin sample
//  sample_cos   out  WIDTH            signed cos sample
//  sample_id    out  $clog2(NUM_REQ)  owner of current burst
//  sample_last  out  1                final sample of burst
//  done         out  1                one-cycle pulse, cycle after last handshake
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): state IDLE, all outputs 0, rr pointer=0, oscillator (0,R).
//    Applies mid-burst: burst discarded, no done pulse.
//  - FSM IDLE->LOAD->RUN->IDLE.
//    IDLE: if any req, pick first set bit at/after rr pointer (wrap), latch id + len -> LOAD.
//    LOAD (1 cycle): gnt[id]=1, busy=1, oscillator seeded; len==0 -> IDLE with done=1, no samples.
//    RUN: sample_valid=1; on valid&&ready: cos<=cos-(sin>>>N), sin<=sin+(cos>>>N)
//      (both from old values, wrap-around two's complement, no saturation), count--.
//    Handshake with count==1 (sample_last=1) -> IDLE; next cycle done=1, busy=0,
//      rr pointer=id+1 mod NUM_REQ.
//  - Latency: req seen in IDLE at cycle t -> gnt at t+1 -> first sample_valid at t+2.
//  - Backpressure: while valid && !ready, sin/cos/id/last held stable, no step.
//  - req deasserted mid-burst: ignored (burst committed). req_len sampled only in IDLE.
//  - Back-to-back: IDLE lasts at least 1 cycle between bursts; done and next arbitration
//    evaluate in the same cycle.
// CONFIGURATION
//  SINCOS_PHASE_KEEP_EN defined: per-requester saved (sin,cos) pair, reset to (0,R);
//    LOAD seeds from requester's pair; burst end stores the next (un-emitted) pair,
//    so consecutive bursts of one requester form a continuous waveform.
//  Not defined: LOAD always seeds (0,R); no per-requester storage.
// STRUCTURE
//  Package sincos_pkg: state_t enum {IDLE,LOAD,RUN}, function sincos_r(width) returning
//    2**(width-2), typedef of sin/cos pair struct.
//  Sub-module sincos_rotator: registers sin/cos, inputs load/load_sin/load_cos/step,
//    one Minsky step per step pulse.
// TESTING
//  1. Reset, req=4'b0001, len0=3, ready=1 -> gnt=0001 at t+1;
//     samples (sin,cos)=(0,16384),(512,16384),(1024,16368) with last on 3rd; done next cycle.
//  2. req=4'b1111 held, all len=1 -> grants 0001,0010,0100,1000,0001 in order; sample_id matches.
//  3. Burst len=2, ready low 5 cycles on first sample -> (0,16384) held stable, no step,
//     then (512,16384).
//  4. len=0 -> gnt pulse, zero sample_valid cycles, done one cycle after LOAD.
//  5. reset_n=0 during RUN -> next cycle valid=0, busy=0, no done; new req restarts at (0,16384).
//  6. SINCOS_PHASE_KEEP_EN: req0 len=2 then len=1 -> second burst emits (1024,16368);
//     undefined -> (0,16384).

Source files
------------

// File: rtl/sincos_pkg.sv
// ---------------------------------------------------------------------------
// sincos_pkg : shared types and helpers for the sin/cos burst scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sincos_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int SC_DEF_WIDTH = 16;

    // Default-width pair, for consumers that fix the sample width.
    typedef struct packed {
        logic signed [SC_DEF_WIDTH-1:0] sin;
        logic signed [SC_DEF_WIDTH-1:0] cos;
    } sc_pair_t;

    function automatic int sincos_r(input int width);
        return 2 ** (width - 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sincos_rotator.sv
// ---------------------------------------------------------------------------
// sincos_rotator : Minsky-rotation sin/cos register pair, one step per pulse
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sincos_rotator
    import sincos_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load_i,
    input  logic signed [WIDTH-1:0] load_sin_i,
    input  logic signed [WIDTH-1:0] load_cos_i,
    input  logic                    step_i,
    output logic signed [WIDTH-1:0] sin_o,
    output logic signed [WIDTH-1:0] cos_o,
    output logic signed [WIDTH-1:0] nxt_sin_o,
    output logic signed [WIDTH-1:0] nxt_cos_o
);

    localparam logic signed [WIDTH-1:0] C_R = WIDTH'(sincos_r(WIDTH));

    logic signed [WIDTH-1:0] sin_q, sin_d;
    logic signed [WIDTH-1:0] cos_q, cos_d;

    // Both updates use the old values; wrap-around is intentional.
    assign nxt_cos_o = cos_q - (sin_q >>> N);
    assign nxt_sin_o = sin_q + (cos_q >>> N);

    always_comb begin
        sin_d = sin_q;
        cos_d = cos_q;
        if (load_i) begin
            sin_d = load_sin_i;
            cos_d = load_cos_i;
        end else if (step_i) begin
            sin_d = nxt_sin_o;
            cos_d = nxt_cos_o;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sin_q <= '0;
            cos_q <= C_R;
        end else begin
            sin_q <= sin_d;
            cos_q <= cos_d;
        end
    end

    assign sin_o = sin_q;
    assign cos_o = cos_q;

endmodule

`default_nettype wire

// File: rtl/sincos_burst_sched.sv
// ---------------------------------------------------------------------------
// sincos_burst_sched : round-robin burst scheduler around a shared sin/cos
// oscillator. Optional SINCOS_PHASE_KEEP_EN keeps per-requester phase.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sincos_burst_sched
    import sincos_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int N       = 5,
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    output logic                       sample_valid,
    input  logic                       sample_ready,
    output logic signed [WIDTH-1:0]    sample_sin,
    output logic signed [WIDTH-1:0]    sample_cos,
    output logic [$clog2(NUM_REQ)-1:0] sample_id,
    output logic                       sample_last,
    output logic                       done
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic signed [WIDTH-1:0] C_R = WIDTH'(sincos_r(WIDTH));

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic              done_q, done_d;

    logic              w_found;
    logic [ID_W-1:0]   w_pick;
    logic [ID_W:0]     w_idx;
    logic [LEN_W-1:0]  w_len;
    logic [ID_W-1:0]   w_id_inc;
    logic              w_hs;
    logic              w_end;
    logic              w_load;
    logic signed [WIDTH-1:0] w_seed_sin, w_seed_cos;
    logic signed [WIDTH-1:0] w_sin, w_cos, w_nxt_sin, w_nxt_cos;

    // First requester at or after the round-robin pointer, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, rr_q} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(NUM_REQ))
                w_idx = w_idx - (ID_W+1)'(NUM_REQ);
            if (!w_found && req[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_len = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_pick == ID_W'(k))
                w_len = req_len[k*LEN_W +: LEN_W];
        end
    end

    assign w_id_inc = (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + ID_W'(1);
    assign w_hs     = (state_q == RUN) && sample_ready;
    assign w_end    = w_hs && (count_q == LEN_W'(1));
    assign w_load   = (state_q == LOAD);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        rr_d    = rr_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_found) begin
                    id_d    = w_pick;
                    count_d = w_len;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (count_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    rr_d    = w_id_inc;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_hs) begin
                    count_d = count_q - LEN_W'(1);
                    if (w_end) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        rr_d    = w_id_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            id_q    <= '0;
            rr_q    <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

`ifdef SINCOS_PHASE_KEEP_EN
    logic signed [WIDTH-1:0] psin_q [NUM_REQ];
    logic signed [WIDTH-1:0] pcos_q [NUM_REQ];

    // Burst end saves the pair that would have been emitted next.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                psin_q[k] <= '0;
                pcos_q[k] <= C_R;
            end
        end else if (w_end) begin
            psin_q[id_q] <= w_nxt_sin;
            pcos_q[id_q] <= w_nxt_cos;
        end
    end

    assign w_seed_sin = psin_q[id_q];
    assign w_seed_cos = pcos_q[id_q];
`else
    assign w_seed_sin = '0;
    assign w_seed_cos = C_R;
`endif

    sincos_rotator #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_rot (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (w_load),
        .load_sin_i (w_seed_sin),
        .load_cos_i (w_seed_cos),
        .step_i     (w_hs),
        .sin_o      (w_sin),
        .cos_o      (w_cos),
        .nxt_sin_o  (w_nxt_sin),
        .nxt_cos_o  (w_nxt_cos)
    );

    always_comb begin
        gnt = '0;
        for (int k = 0; k < NUM_REQ; k++)
            gnt[k] = w_load && (id_q == ID_W'(k));
    end

    assign busy         = (state_q == LOAD) || (state_q == RUN);
    assign sample_valid = (state_q == RUN);
    assign sample_sin   = sample_valid ? w_sin : '0;
    assign sample_cos   = sample_valid ? w_cos : '0;
    assign sample_id    = sample_valid ? id_q  : '0;
    assign sample_last  = sample_valid && (count_q == LEN_W'(1));
    assign done         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sincos_burst_sched.sv
// ---------------------------------------------------------------------------
// tb_sincos_burst_sched : directed self-checking bench for sincos_burst_sched
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sincos_burst_sched;

    localparam int WIDTH   = 16;
    localparam int N       = 5;
    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 8;
    localparam int R       = 16384;

    logic                       clk;
    logic                       reset_n;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*LEN_W-1:0]   req_len;
    logic [NUM_REQ-1:0]         gnt;
    logic                       busy;
    logic                       sample_valid;
    logic                       sample_ready;
    logic signed [WIDTH-1:0]    sample_sin;
    logic signed [WIDTH-1:0]    sample_cos;
    logic [1:0]                 sample_id;
    logic                       sample_last;
    logic                       done;

    int n_checks;
    int n_fail;

    sincos_burst_sched #(
        .WIDTH   (WIDTH),
        .N       (N),
        .NUM_REQ (NUM_REQ),
        .LEN_W   (LEN_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .req_len      (req_len),
        .gnt          (gnt),
        .busy         (busy),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_sin   (sample_sin),
        .sample_cos   (sample_cos),
        .sample_id    (sample_id),
        .sample_last  (sample_last),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int r, input int l);
        req_len[r*LEN_W +: LEN_W] = LEN_W'(l);
    endtask

    task automatic exp_sample(input string tag, input int s, input int c,
                              input int id, input int last);
        check({tag, "_valid"}, int'(sample_valid), 1);
        check({tag, "_sin"},   int'(sample_sin),   s);
        check({tag, "_cos"},   int'(sample_cos),   c);
        check({tag, "_id"},    int'(sample_id),    id);
        check({tag, "_last"},  int'(sample_last),  last);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        tick();
        tick();
        check("rst_valid", int'(sample_valid), 0);
        check("rst_busy",  int'(busy),         0);
        check("rst_gnt",   int'(gnt),          0);
        check("rst_done",  int'(done),         0);
        check("rst_cos",   int'(sample_cos),   0);
        reset_n = 1'b1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        req          = '0;
        req_len      = '0;
        sample_ready = 1'b1;

        // 1: single burst of three
        do_reset();
        req = 4'b0001;
        set_len(0, 3);
        tick();
        check("t1_gnt",  int'(gnt),  1);
        check("t1_busy", int'(busy), 1);
        check("t1_load_valid", int'(sample_valid), 0);
        req = '0;
        tick(); exp_sample("t1_s0", 0,    R,     0, 0);
        tick(); exp_sample("t1_s1", 512,  R,     0, 0);
        tick(); exp_sample("t1_s2", 1024, 16368, 0, 1);
        tick();
        check("t1_done",  int'(done),         1);
        check("t1_busy0", int'(busy),         0);
        check("t1_valid0", int'(sample_valid), 0);
        tick();
        check("t1_done_pulse", int'(done), 0);

        // 2: round-robin over all four requesters
        do_reset();
        req = 4'b1111;
        for (int r = 0; r < NUM_REQ; r++) set_len(r, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_gnt", int'(gnt), 1 << (i % NUM_REQ));
            tick();
            check("t2_id",   int'(sample_id),   i % NUM_REQ);
            check("t2_last", int'(sample_last), 1);
            tick();
            check("t2_done", int'(done), 1);
        end
        req = '0;

        // 3: backpressure on first sample
        do_reset();
        req = 4'b0001;
        set_len(0, 2);
        tick();
        check("t3_gnt", int'(gnt), 1);
        req = '0;
        sample_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_sample("t3_hold", 0, R, 0, 0);
        end
        sample_ready = 1'b1;
        tick(); exp_sample("t3_s1", 512, R, 0, 1);
        tick();
        check("t3_done", int'(done), 1);

        // 4: zero-length burst
        do_reset();
        req = 4'b0001;
        set_len(0, 0);
        tick();
        check("t4_gnt",  int'(gnt),  1);
        check("t4_busy", int'(busy), 1);
        req = '0;
        tick();
        check("t4_valid", int'(sample_valid), 0);
        check("t4_done",  int'(done),         1);
        tick();
        check("t4_done_pulse", int'(done),         0);
        check("t4_valid2",     int'(sample_valid), 0);

        // 5: reset during RUN
        do_reset();
        req = 4'b0001;
        set_len(0, 3);
        tick();
        req = '0;
        tick(); exp_sample("t5_s0", 0,   R, 0, 0);
        tick(); exp_sample("t5_s1", 512, R, 0, 0);
        reset_n = 1'b0;
        tick();
        check("t5_rst_valid", int'(sample_valid), 0);
        check("t5_rst_busy",  int'(busy),         0);
        check("t5_rst_done",  int'(done),         0);
        reset_n = 1'b1;
        tick();
        check("t5_no_done", int'(done), 0);
        req = 4'b0001;
        set_len(0, 1);
        tick();
        check("t5_gnt", int'(gnt), 1);
        req = '0;
        tick(); exp_sample("t5_restart", 0, R, 0, 1);
        tick();
        check("t5_done", int'(done), 1);

        // 6: second burst of one requester, phase continuity option
        do_reset();
        req = 4'b0001;
        set_len(0, 2);
        tick();
        req = '0;
        tick(); exp_sample("t6_a0", 0,   R, 0, 0);
        tick(); exp_sample("t6_a1", 512, R, 0, 1);
        req = 4'b0001;
        set_len(0, 1);
        tick();
        check("t6_done", int'(done), 1);
        tick();
        check("t6_gnt", int'(gnt), 1);
        req = '0;
        tick();
`ifdef SINCOS_PHASE_KEEP_EN
        exp_sample("t6_b0", 1024, 16368, 0, 1);
`else
        exp_sample("t6_b0", 0, R, 0, 1);
`endif
        tick();
        check("t6_done2", int'(done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
